// File: rtl/simd_host_pkg.sv
// simd_host_pkg: shared types and constants for the SIMD host controller
package simd_host_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/simd_host_ctrl_if.sv
// simd_host_ctrl_if: host/processor-facing signals of the SIMD host controller
interface simd_host_ctrl_if #(parameter int N = 512);
   localparam int AW = $clog2(N);
   logic                                LOAD_EN;
   logic [AW-1:0]                       LOAD_ADDR;
   logic [simd_host_pkg::INSTR_W-1:0]   LOAD_DATA;
   logic                                GO;
   logic                                ABORT;
   logic [AW-1:0]                       PC_AXI;
   logic [simd_host_pkg::INSTR_W-1:0]   INSTR_AXI;
   logic                                START_SIGNAL;
   logic                                STOP_SIGNAL;
   logic                                BUSY;
   logic                                DONE;
   logic                                TIMEOUT;
   logic [31:0]                         CYCLE_COUNT;
   modport master (
      output LOAD_EN, LOAD_ADDR, LOAD_DATA, GO, ABORT, PC_AXI, STOP_SIGNAL,
      input  INSTR_AXI, START_SIGNAL, BUSY, DONE, TIMEOUT, CYCLE_COUNT
   );
   modport slave (
      input  LOAD_EN, LOAD_ADDR, LOAD_DATA, GO, ABORT, PC_AXI, STOP_SIGNAL,
      output INSTR_AXI, START_SIGNAL, BUSY, DONE, TIMEOUT, CYCLE_COUNT
   );
endinterface

// File: rtl/simd_instr_mem.sv
// simd_instr_mem: N x 32 simple dual-port instruction store, registered read-first fetch
module simd_instr_mem
   import simd_host_pkg::*;
#(
   parameter  int N  = 512,
   localparam int AW = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [INSTR_W-1:0] rdata
);
   logic [INSTR_W-1:0] mem [N];
   // host write port; array is never reset so the program survives RST
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   // fetch port sees the pre-write contents on a same-address collision
   always_ff @(posedge clk)
      rdata <= rst ? NOP_INSTR : mem[raddr];
endmodule

// File: rtl/simd_host_ctrl.sv
// simd_host_ctrl: instruction store plus run handshake, cycle counter and timeout
module simd_host_ctrl
   import simd_host_pkg::*;
#(
   parameter int N              = 512,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input logic             CLK,
   input logic             RST,
   simd_host_ctrl_if.slave bus
);
   localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);
   state_t      state;
   logic [31:0] cnt_nxt;
   assign cnt_nxt = bus.CYCLE_COUNT + 32'd1;
   simd_instr_mem #(.N(N)) u_mem (
      .clk   (CLK),
      .rst   (RST),
      .we    (bus.LOAD_EN && state != RUN),
      .waddr (bus.LOAD_ADDR),
      .wdata (bus.LOAD_DATA),
      .raddr (bus.PC_AXI),
      .rdata (bus.INSTR_AXI)
   );
   // run FSM: abort beats stop, stop beats timeout, a stale stop blocks GO
   always_ff @(posedge CLK)
      if (RST) begin
         state            <= IDLE;
         bus.START_SIGNAL <= 1'b0;
         bus.BUSY         <= 1'b0;
         bus.DONE         <= 1'b0;
         bus.TIMEOUT      <= 1'b0;
         bus.CYCLE_COUNT  <= 32'd0;
      end else if (bus.ABORT) begin
         state            <= IDLE;
         bus.START_SIGNAL <= 1'b0;
         bus.BUSY         <= 1'b0;
         bus.DONE         <= 1'b0;
         bus.TIMEOUT      <= 1'b0;
      end else if (state == RUN) begin
         bus.CYCLE_COUNT <= cnt_nxt;
         if (bus.STOP_SIGNAL || cnt_nxt == TMO) begin
            state            <= DONE;
            bus.START_SIGNAL <= 1'b0;
            bus.BUSY         <= 1'b0;
            bus.DONE         <= 1'b1;
            bus.TIMEOUT      <= !bus.STOP_SIGNAL;
         end
      end else if (bus.GO && !bus.STOP_SIGNAL) begin
         state            <= RUN;
         bus.START_SIGNAL <= 1'b1;
         bus.BUSY         <= 1'b1;
         bus.DONE         <= 1'b0;
         bus.TIMEOUT      <= 1'b0;
         bus.CYCLE_COUNT  <= 32'd0;
      end
endmodule
